cpu_fetch_queue: RTL and testbench
==================================

// Module: cpu_fetch_queue
// PURPOSE
//  Next-generation instruction fetch stage with a parametrised prefetch queue between the bus and decode.
//  Issues sequential reads while the queue has space; stops after control-flow or trap instructions.
//  Resumes on explicit jump or IRQ. Delivers {pc, instruction} to decode over a valid/ready handshake.
// PARAMETERS
//  RESET_VECTOR  32'h0  first fetch address after reset
//  QUEUE_DEPTH   4      prefetch queue entries; power of two, >= 2
// PORTS
//  i_clock           in   1   clock
//  i_reset_n         in   1   reset, asynchronous, active-low
//  i_jump            in   1   resume pulse; valid only in WAIT_JUMP
//  i_jump_pc         in   32  resume address
//  i_irq_pending     in   1   interrupt level; a rising edge requests dispatch
//  i_irq_pc          in   32  handler vector
//  o_irq_dispatched  out  1   one-cycle pulse when IRQ is taken
//  o_irq_epc         out  32  return PC, valid with o_irq_dispatched
//  o_bus_request     out  1   read request, held until i_bus_ready
//  i_bus_ready       in   1   read complete, i_bus_rdata valid
//  o_bus_address     out  32  read address, word aligned, stable while requested
//  i_bus_rdata       in   32  read data
//  o_valid           out  1   queue head valid
//  i_ready           in   1   decode accepts head
//  o_pc              out  32  head PC
//  o_instruction     out  32  head instruction
//  o_count           out  $clog2(QUEUE_DEPTH)+1  queue occupancy
//  o_debug_pc        out  32  next fetch PC
// BEHAVIOUR
//  - Reset (async assert, sync release): state=FETCH, fetch pc=RESET_VECTOR, queue empty, all outputs 0.
//  - One bus transaction outstanding at most. Request starts the cycle after the FSM decides to fetch.
//  - FETCH: request at pc when no request is pending and count + pending < QUEUE_DEPTH. On i_bus_ready,
//    push {pc, rdata}; count must never exceed QUEUE_DEPTH.
//    * Opcode JAL, JALR or BRANCH, or instr == 32'h30200073 (MRET): push, then go to WAIT_JUMP. pc is not advanced.
//    * instr == 32'h00000073 (ECALL) or 32'h10500073 (WFI): push, then go to WAIT_IRQ.
//    * Otherwise push, then pc <= pc+4.
//  - WAIT_JUMP: no new requests. When i_jump is high: pc<=i_jump_pc, state=FETCH. Fetch begins next cycle.
//    i_jump is ignored in other states.
//  - WAIT_IRQ: no new requests.
//  - Output side: o_valid = count != 0. A pop occurs when o_valid && i_ready.
//    Push and pop in the same cycle are legal, including when the queue is full (a pop frees the slot).
//    Head data comes straight from the registered storage. No output bypass: a word written on cycle N is visible at N+1.
//  - IRQ sampling: irq_r <= i_irq_pending every cycle. An edge is {irq_r, i_irq_pending} == 2'b01.
//    * FETCH: dispatch. epc = head pc if o_valid, else the fetch pc.
//    * WAIT_IRQ: dispatch only when the queue is empty (trap instruction already consumed); epc = pc.
//      If the queue is not empty, the edge is held pending until it empties.
//    * WAIT_JUMP: an edge is ignored.
//    * On dispatch: o_irq_dispatched=1 for one cycle, o_irq_epc latched, queue flushed (count=0, o_valid=0
//      next cycle), pc<=i_irq_pc, state=FETCH.
//    * A pop in the dispatch cycle is suppressed: o_valid is forced low while the edge is detected.
//  - In-flight read at a flush: the request stays asserted until i_bus_ready. The returned word is discarded.
//    The next request goes out at the new pc the following cycle.
//  - pc arithmetic wraps modulo 2^32. o_bus_address = {pc[31:2], 2'b00}.
//  - Illegal state encodings return to FETCH.
// TESTING
//  1 Zero-wait bus, i_ready=1, 8 NOPs from 0x0 -> o_pc 0x0,0x4,...,0x1C in order, no gaps after fill.
//  2 i_ready=0, QUEUE_DEPTH=4 -> o_count saturates at 4, no 5th request; one pop -> exactly one new request.
//  3 BEQ at 0x8 -> fetch stops, head sequence 0x0,0x4,0x8; i_jump_pc=0x100 -> next o_pc 0x100.
//  4 Queue holds 0x10..0x1C; rising i_irq_pending, i_irq_pc=0x200 -> epc=0x10, pulse 1 cycle, queue empty, next o_pc 0x200.
//  5 IRQ edge during an outstanding 3-wait-state read -> returned word dropped, next address 0x200.
//  6 ECALL at 0x40 still queued, then IRQ edge -> no dispatch until pop; then dispatch with epc=0x40.
//  7 Reset asserted mid-read -> all outputs 0 immediately; after release, first address = RESET_VECTOR.

Source files
------------

// File: rtl/cpu_fetch_queue.sv
// cpu_fetch_queue: instruction fetch stage with a prefetch queue between the bus and decode.
// Fetches sequentially, parks after control-flow/trap instructions, resumes on jump or IRQ.
module cpu_fetch_queue #(
    parameter logic [31:0] RESET_VECTOR = 32'h0,
    parameter int          QUEUE_DEPTH  = 4
) (
    input  logic                          i_clock,
    input  logic                          i_reset_n,
    input  logic                          i_jump,
    input  logic [31:0]                   i_jump_pc,
    input  logic                          i_irq_pending,
    input  logic [31:0]                   i_irq_pc,
    output logic                          o_irq_dispatched,
    output logic [31:0]                   o_irq_epc,
    output logic                          o_bus_request,
    input  logic                          i_bus_ready,
    output logic [31:0]                   o_bus_address,
    input  logic [31:0]                   i_bus_rdata,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [31:0]                   o_pc,
    output logic [31:0]                   o_instruction,
    output logic [$clog2(QUEUE_DEPTH):0]  o_count,
    output logic [31:0]                   o_debug_pc
);
    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [31:0] ECALL = 32'h00000073;
    localparam logic [31:0] WFI   = 32'h10500073;
    localparam logic [31:0] MRET  = 32'h30200073;

    typedef enum logic [1:0] {FETCH = 2'd0, WAIT_JUMP = 2'd1, WAIT_IRQ = 2'd2} state_t;

    state_t         state_q, state_d;
    logic [31:0]    pc_q, pc_d, addr_q, addr_d, epc_q, epc_d;
    logic           req_q, req_d, drop_q, drop_d, irq_r_q, hold_q, hold_d, disp_q;
    logic [CW-1:0]  count_q, count_d;
    logic [AW-1:0]  rd_q, rd_d, wr_q, wr_d;
    logic [31:0]    pc_mem_q  [QUEUE_DEPTH];
    logic [31:0]    ins_mem_q [QUEUE_DEPTH];
    logic           irq_edge, dispatch, valid, pop, push, busy, issue, is_jump, is_trap;
    logic [6:0]     opcode;

    always_comb begin
        irq_edge = i_irq_pending && !irq_r_q;
        dispatch = (state_q == FETCH && irq_edge)
                || (state_q == WAIT_IRQ && (irq_edge || hold_q) && count_q == '0);
        valid    = count_q != '0 && !irq_edge;
        pop      = valid && i_ready;
        // A word returning after a flush is marked for drop and never enters the queue
        push     = req_q && i_bus_ready && !drop_q && !dispatch && state_q == FETCH;
        busy     = req_q && !i_bus_ready;
        opcode   = i_bus_rdata[6:0];
        is_jump  = opcode == 7'b1101111 || opcode == 7'b1100111 || opcode == 7'b1100011
                || i_bus_rdata == MRET;
        is_trap  = i_bus_rdata == ECALL || i_bus_rdata == WFI;
        state_d  = dispatch ? FETCH
                 : (push && is_jump) ? WAIT_JUMP
                 : (push && is_trap) ? WAIT_IRQ
                 : (state_q == WAIT_JUMP && i_jump) ? FETCH
                 : (state_q == FETCH || state_q == WAIT_JUMP || state_q == WAIT_IRQ) ? state_q
                 : FETCH;
        pc_d     = dispatch ? i_irq_pc
                 : (state_q == WAIT_JUMP && i_jump) ? i_jump_pc
                 : (push && !is_jump && !is_trap) ? pc_q + 32'd4
                 : pc_q;
        hold_d   = dispatch ? 1'b0 : (state_q == WAIT_IRQ && irq_edge) ? 1'b1 : hold_q;
        count_d  = dispatch ? '0 : count_q + CW'(push) - CW'(pop);
        rd_d     = dispatch ? '0 : rd_q + AW'(pop);
        wr_d     = dispatch ? '0 : wr_q + AW'(push);
        issue    = !busy && state_d == FETCH && count_d < CW'(QUEUE_DEPTH);
        req_d    = busy || issue;
        drop_d   = busy && (drop_q || dispatch);
        addr_d   = issue ? {pc_d[31:2], 2'b00} : addr_q;
        epc_d    = !dispatch ? epc_q
                 : (state_q == FETCH && count_q != '0) ? pc_mem_q[rd_q] : pc_q;
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_VECTOR;
            addr_q  <= '0;
            epc_q   <= '0;
            req_q   <= 1'b0;
            drop_q  <= 1'b0;
            irq_r_q <= 1'b0;
            hold_q  <= 1'b0;
            disp_q  <= 1'b0;
            count_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                pc_mem_q[i]  <= '0;
                ins_mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            epc_q   <= epc_d;
            req_q   <= req_d;
            drop_q  <= drop_d;
            irq_r_q <= i_irq_pending;
            hold_q  <= hold_d;
            disp_q  <= dispatch;
            count_q <= count_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            if (push) begin
                pc_mem_q[wr_q]  <= pc_q;
                ins_mem_q[wr_q] <= i_bus_rdata;
            end
        end
    end

    assign o_irq_dispatched = disp_q;
    assign o_irq_epc        = epc_q;
    assign o_bus_request    = req_q;
    assign o_bus_address    = addr_q;
    assign o_valid          = valid;
    assign o_pc             = pc_mem_q[rd_q];
    assign o_instruction    = ins_mem_q[rd_q];
    assign o_count          = count_q;
    assign o_debug_pc       = pc_q;
endmodule

// File: tb/tb_cpu_fetch_queue.sv
// tb_cpu_fetch_queue: directed scenarios for the fetch queue against a small wait-state bus model.
module tb_cpu_fetch_queue;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0, rst_n = 1'b0, jump = 1'b0, irq = 1'b0, ready = 1'b0;
    logic [31:0] jump_pc = '0, irq_pc = '0;
    logic        disp, req, bus_ready, valid;
    logic [31:0] epc, addr, rdata, pc, instr, dbg_pc;
    logic [2:0]  count;
    logic [31:0] imem [256];
    int          wait_states = 0, wcnt, ntx;
    int          n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    cpu_fetch_queue dut (
        .i_clock(clk), .i_reset_n(rst_n), .i_jump(jump), .i_jump_pc(jump_pc),
        .i_irq_pending(irq), .i_irq_pc(irq_pc), .o_irq_dispatched(disp), .o_irq_epc(epc),
        .o_bus_request(req), .i_bus_ready(bus_ready), .o_bus_address(addr), .i_bus_rdata(rdata),
        .o_valid(valid), .i_ready(ready), .o_pc(pc), .o_instruction(instr),
        .o_count(count), .o_debug_pc(dbg_pc)
    );

    // Bus responder: completes a request after wait_states stall cycles
    assign bus_ready = req && (wcnt == wait_states);
    assign rdata     = imem[addr[9:2]];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt <= 0;
            ntx  <= 0;
        end else begin
            wcnt <= (req && !bus_ready) ? wcnt + 1 : 0;
            if (req && bus_ready) ntx <= ntx + 1;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic init_mem;
        for (int i = 0; i < 256; i++) imem[i] = NOP;
    endtask

    task automatic do_reset(input int ws);
        rst_n = 1'b0; wait_states = ws; ready = 1'b0; irq = 1'b0; jump = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        init_mem;
        rst_n = 1'b0;
        step(1);
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", req); end
        n_checks++; if (addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", addr); end
        n_checks++; if (dbg_pc !== 32'h0) begin n_fail++; $display("FAIL reset_dbg_pc: got %h expected 0", dbg_pc); end
        n_checks++; if ({disp, epc} !== 33'h0) begin n_fail++; $display("FAIL reset_irq: got %b/%h expected 0/0", disp, epc); end
        n_checks++; if ({pc, instr} !== 64'h0) begin n_fail++; $display("FAIL reset_head: got %h/%h expected 0/0", pc, instr); end
    endtask

    task automatic test_stream;
        int t = 0;
        init_mem; do_reset(0); ready = 1'b1;
        while (!valid && t < 20) begin step(1); t++; end
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if ({valid, pc} !== {1'b1, 32'(k * 4)}) begin
                n_fail++; $display("FAIL stream[%0d]: got valid=%b pc=%h expected valid=1 pc=%h", k, valid, pc, k * 4);
            end
            step(1);
        end
    endtask

    task automatic test_full;
        init_mem; do_reset(0);
        step(10);
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d expected 4", count); end
        n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL full_no_req: got %b expected 0", req); end
        n_checks++; if (ntx !== 4) begin n_fail++; $display("FAIL full_ntx: got %0d expected 4", ntx); end
        jump_pc = 32'h300; jump = 1'b1; step(1); jump = 1'b0;
        n_checks++; if (dbg_pc !== 32'h10) begin n_fail++; $display("FAIL jump_ignored: got %h expected 10", dbg_pc); end
        ready = 1'b1; step(1); ready = 1'b0;
        n_checks++; if ({req, addr, count} !== {1'b1, 32'h10, 3'd3}) begin
            n_fail++; $display("FAIL refill_req: got req=%b addr=%h count=%0d expected 1/10/3", req, addr, count);
        end
        step(6);
        n_checks++; if (ntx !== 5) begin n_fail++; $display("FAIL refill_ntx: got %0d expected 5", ntx); end
        n_checks++; if ({count, req, pc} !== {3'd4, 1'b0, 32'h4}) begin
            n_fail++; $display("FAIL refill_state: got count=%0d req=%b pc=%h expected 4/0/4", count, req, pc);
        end
    endtask

    task automatic test_branch;
        logic [31:0] seen[$];
        logic [31:0] v;
        int t = 0;
        init_mem; imem[2] = 32'h00000063; do_reset(0); ready = 1'b1;
        repeat (12) begin
            if (valid) seen.push_back(pc);
            step(1);
        end
        n_checks++; if (seen.size() !== 3) begin n_fail++; $display("FAIL branch_len: got %0d expected 3", seen.size()); end
        for (int k = 0; k < 3; k++) begin
            v = (k < seen.size()) ? seen[k] : 32'hFFFF_FFFF;
            n_checks++; if (v !== 32'(k * 4)) begin n_fail++; $display("FAIL branch_seq[%0d]: got %h expected %h", k, v, k * 4); end
        end
        n_checks++; if ({req, dbg_pc} !== {1'b0, 32'h8}) begin
            n_fail++; $display("FAIL branch_park: got req=%b pc=%h expected 0/8", req, dbg_pc);
        end
        jump_pc = 32'h100; jump = 1'b1; step(1); jump = 1'b0;
        n_checks++; if ({req, addr} !== {1'b1, 32'h100}) begin
            n_fail++; $display("FAIL jump_req: got req=%b addr=%h expected 1/100", req, addr);
        end
        while (!valid && t < 10) begin step(1); t++; end
        n_checks++; if ({valid, pc} !== {1'b1, 32'h100}) begin
            n_fail++; $display("FAIL jump_head: got valid=%b pc=%h expected 1/100", valid, pc);
        end
    endtask

    task automatic test_irq_fetch;
        int t = 0;
        init_mem; do_reset(0); ready = 1'b1;
        while (!(valid && pc == 32'h10) && t < 40) begin step(1); t++; end
        ready = 1'b0;
        step(6);
        n_checks++; if ({count, pc} !== {3'd4, 32'h10}) begin
            n_fail++; $display("FAIL irq_pre: got count=%0d pc=%h expected 4/10", count, pc);
        end
        irq_pc = 32'h200; irq = 1'b1; #1;
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL irq_valid_mask: got %b expected 0", valid); end
        step(1);
        n_checks++; if ({disp, epc} !== {1'b1, 32'h10}) begin
            n_fail++; $display("FAIL irq_dispatch: got disp=%b epc=%h expected 1/10", disp, epc);
        end
        n_checks++; if ({count, valid, req, addr} !== {3'd0, 1'b0, 1'b1, 32'h200}) begin
            n_fail++; $display("FAIL irq_flush: got count=%0d valid=%b req=%b addr=%h expected 0/0/1/200", count, valid, req, addr);
        end
        step(1);
        n_checks++; if ({disp, valid, pc} !== {1'b0, 1'b1, 32'h200}) begin
            n_fail++; $display("FAIL irq_after: got disp=%b valid=%b pc=%h expected 0/1/200", disp, valid, pc);
        end
        irq = 1'b0;
    endtask

    task automatic test_irq_inflight;
        int t = 0;
        init_mem; do_reset(3); ready = 1'b1;
        while (!(req && addr == 32'h4 && wcnt == 1) && t < 40) begin step(1); t++; end
        irq_pc = 32'h200; irq = 1'b1;
        step(1);
        n_checks++; if ({disp, epc, req, addr, dbg_pc} !== {1'b1, 32'h4, 1'b1, 32'h4, 32'h200}) begin
            n_fail++; $display("FAIL inflight_dispatch: got disp=%b epc=%h req=%b addr=%h pc=%h expected 1/4/1/4/200", disp, epc, req, addr, dbg_pc);
        end
        t = 0;
        while (addr == 32'h4 && t < 10) begin step(1); t++; end
        n_checks++; if ({addr, count} !== {32'h200, 3'd0}) begin
            n_fail++; $display("FAIL inflight_drop: got addr=%h count=%0d expected 200/0", addr, count);
        end
        t = 0;
        while (!valid && t < 20) begin step(1); t++; end
        n_checks++; if ({valid, pc} !== {1'b1, 32'h200}) begin
            n_fail++; $display("FAIL inflight_head: got valid=%b pc=%h expected 1/200", valid, pc);
        end
        irq = 1'b0;
    endtask

    task automatic test_irq_wait;
        int t = 0;
        logic seen_disp = 1'b0;
        init_mem; imem[16] = 32'h00000073; do_reset(0); ready = 1'b1;
        while (!(valid && pc == 32'h40) && t < 60) begin step(1); t++; end
        ready = 1'b0;
        step(3);
        n_checks++; if ({count, req, dbg_pc} !== {3'd1, 1'b0, 32'h40}) begin
            n_fail++; $display("FAIL ecall_park: got count=%0d req=%b pc=%h expected 1/0/40", count, req, dbg_pc);
        end
        irq_pc = 32'h200; irq = 1'b1;
        repeat (4) begin
            step(1);
            if (disp) seen_disp = 1'b1;
        end
        n_checks++; if ({seen_disp, count, valid} !== {1'b0, 3'd1, 1'b1}) begin
            n_fail++; $display("FAIL ecall_hold: got disp=%b count=%0d valid=%b expected 0/1/1", seen_disp, count, valid);
        end
        ready = 1'b1; step(1); ready = 1'b0;
        t = 0;
        while (!disp && t < 5) begin step(1); t++; end
        n_checks++; if ({disp, epc, dbg_pc} !== {1'b1, 32'h40, 32'h200}) begin
            n_fail++; $display("FAIL ecall_dispatch: got disp=%b epc=%h pc=%h expected 1/40/200", disp, epc, dbg_pc);
        end
        irq = 1'b0;
    endtask

    task automatic test_reset_midread;
        int t = 0;
        init_mem; do_reset(3);
        while (!(count != 0 && req && wcnt == 1) && t < 40) begin step(1); t++; end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({valid, count, req, addr, dbg_pc} !== 70'h0) begin
            n_fail++; $display("FAIL midreset_outputs: got valid=%b count=%0d req=%b addr=%h pc=%h expected all 0", valid, count, req, addr, dbg_pc);
        end
        n_checks++; if ({pc, instr} !== 64'h0) begin n_fail++; $display("FAIL midreset_head: got %h/%h expected 0/0", pc, instr); end
        step(1);
        rst_n = 1'b1;
        t = 0;
        while (!req && t < 10) begin step(1); t++; end
        n_checks++; if ({req, addr} !== {1'b1, 32'h0}) begin
            n_fail++; $display("FAIL midreset_first: got req=%b addr=%h expected 1/0", req, addr);
        end
        t = 0;
        while (!valid && t < 20) begin step(1); t++; end
        n_checks++; if ({valid, pc, instr} !== {1'b1, 32'h0, NOP}) begin
            n_fail++; $display("FAIL midreset_head2: got valid=%b pc=%h instr=%h expected 1/0/%h", valid, pc, instr, NOP);
        end
    endtask

    initial begin
        test_reset;
        test_stream;
        test_full;
        test_branch;
        test_irq_fetch;
        test_irq_inflight;
        test_irq_wait;
        test_reset_midread;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
